// File: rtl/teclado_cajero.sv
// rtl/teclado_cajero.sv - 4x3 keypad scanner with debounce and PIN digit strobes
// Scans one column at a time, confirms a single-key press, then waits for full release.
module teclado_cajero #(
  parameter int SCAN_CYCLES     = 4,
  parameter int DEBOUNCE_CYCLES = 16
) (
  input  logic       clock,
  input  logic       reset,
  input  logic [3:0] filas,
  output logic [2:0] columnas,
  output logic       digito_stb,
  output logic [3:0] digito,
  output logic       borrar_stb,
  output logic       enviar_stb,
  output logic       pin_completo
);

  localparam int SW = (SCAN_CYCLES > 1) ? $clog2(SCAN_CYCLES) : 1;
  localparam int DW = (DEBOUNCE_CYCLES > 1) ? $clog2(DEBOUNCE_CYCLES) : 1;
  localparam logic [SW-1:0] SCAN_LAST = SW'(SCAN_CYCLES - 1);
  localparam logic [DW-1:0] DEB_LAST  = DW'(DEBOUNCE_CYCLES - 1);

  typedef enum logic [1:0] {ESCANEO, CONFIRMAR, EMITIR, ESPERA_SOLTAR} estado_t;

  estado_t       estado;
  logic [3:0]    filas_m, filas_s, patron;
  logic [SW-1:0] dwell;
  logic [DW-1:0] rebote;
  logic [2:0]    cuenta;

  logic [3:0] bajas;
  logic       una_fila;
  logic [2:0] col_sig;
  logic [1:0] fila_i, col_i;
  logic [3:0] tecla, valor;
  logic       es_borrar, es_enviar;

  assign bajas    = ~filas_s;
  assign una_fila = (bajas != 4'd0) && ((bajas & (bajas - 4'd1)) == 4'd0);
  // Rotating the active-low column left walks 110 -> 101 -> 011 -> 110.
  assign col_sig  = {columnas[1:0], columnas[2]};

  always_comb begin
    fila_i = 2'd3;
    case (~patron)
      4'b0001: fila_i = 2'd0;
      4'b0010: fila_i = 2'd1;
      4'b0100: fila_i = 2'd2;
      default: fila_i = 2'd3;
    endcase
    col_i = 2'd0;
    case (columnas)
      3'b101:  col_i = 2'd1;
      3'b011:  col_i = 2'd2;
      default: col_i = 2'd0;
    endcase
    tecla     = {2'b00, fila_i} * 4'd3 + {2'b00, col_i};
    valor     = (tecla < 4'd9) ? tecla + 4'd1 : 4'd0;
    es_borrar = (tecla == 4'd9);
    es_enviar = (tecla == 4'd11);
  end

  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      filas_m      <= 4'hF;
      filas_s      <= 4'hF;
      patron       <= 4'hF;
      columnas     <= 3'b110;
      digito       <= 4'b1111;
      digito_stb   <= 1'b0;
      borrar_stb   <= 1'b0;
      enviar_stb   <= 1'b0;
      pin_completo <= 1'b0;
      cuenta       <= 3'd0;
      dwell        <= '0;
      rebote       <= '0;
      estado       <= ESCANEO;
    end else begin
      filas_m      <= filas;
      filas_s      <= filas_m;
      pin_completo <= (cuenta == 3'd4);
      digito_stb   <= 1'b0;
      borrar_stb   <= 1'b0;
      enviar_stb   <= 1'b0;
      case (estado)
        ESCANEO: begin
          if (dwell == SCAN_LAST) begin
            dwell <= '0;
            if (una_fila) begin
              patron <= filas_s;
              rebote <= '0;
              estado <= CONFIRMAR;
            end else begin
              columnas <= col_sig;
            end
          end else begin
            dwell <= dwell + 1'b1;
          end
        end
        CONFIRMAR: begin
          if (filas_s == patron) begin
            if (rebote == DEB_LAST) begin
              // Strobes are registered here so they are high during EMITIR.
              rebote <= '0;
              estado <= EMITIR;
              if (es_borrar) begin
                borrar_stb <= 1'b1;
                cuenta     <= 3'd0;
              end else if (es_enviar) begin
                if (cuenta == 3'd4) begin
                  enviar_stb <= 1'b1;
                  cuenta     <= 3'd0;
                end
              end else if (cuenta != 3'd4) begin
                digito_stb <= 1'b1;
                digito     <= valor;
                cuenta     <= cuenta + 3'd1;
              end
            end else begin
              rebote <= rebote + 1'b1;
            end
          end else begin
            rebote   <= '0;
            dwell    <= '0;
            columnas <= col_sig;
            estado   <= ESCANEO;
          end
        end
        EMITIR: begin
          rebote <= '0;
          estado <= ESPERA_SOLTAR;
        end
        ESPERA_SOLTAR: begin
          if (filas_s == 4'hF) begin
            if (rebote == DEB_LAST) begin
              rebote   <= '0;
              dwell    <= '0;
              columnas <= col_sig;
              estado   <= ESCANEO;
            end else begin
              rebote <= rebote + 1'b1;
            end
          end else begin
            rebote <= '0;
          end
        end
        default: estado <= ESCANEO;
      endcase
    end
  end

endmodule
